// File: rtl/wishbone_system_top.sv
// Wishbone classic bring-up subsystem: one master (request regs deposited externally),
// an address-decoding interconnect and two registered-ack slave memories.

module wishbone_master #(
   parameter int WB_WIDTH  = 16,
   parameter int WB_W_DATA = 8
) (
   input  logic                 CLK_i,
   input  logic                 RST_i,
   output logic [WB_WIDTH-1:0]  WBM_ADR_o,
   output logic [WB_W_DATA-1:0] WBM_DAT_o,
   output logic                 WBM_WE_o,
   output logic                 WBM_STB_o,
   output logic                 WBM_CYC_o,
   input  logic [WB_W_DATA-1:0] WBM_DAT_i,
   input  logic                 WBM_ACK_i
);
   logic [WB_WIDTH-1:0]  address;
   logic [WB_W_DATA-1:0] data;
   logic                 write_enable, strobe, cycle;
   logic                 unused_rsp;

   // Request regs are only ever cleared here; between resets they hold whatever
   // was deposited into them from outside, so a plain always is used instead of always_ff.
   always @(posedge CLK_i or negedge RST_i) begin
      if (!RST_i) begin
         address      <= '0;
         data         <= '0;
         write_enable <= 1'b0;
         strobe       <= 1'b0;
         cycle        <= 1'b0;
      end
   end

   assign WBM_ADR_o  = address;
   assign WBM_DAT_o  = data;
   assign WBM_WE_o   = write_enable;
   assign WBM_STB_o  = strobe;
   assign WBM_CYC_o  = cycle;
   assign unused_rsp = ^{WBM_DAT_i, WBM_ACK_i};
endmodule

module wishbone_interface #(
   parameter int WB_WIDTH  = 16,
   parameter int WB_W_DATA = 8,
   parameter int AW        = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WB_WIDTH-1:0]  adr,
   input  logic                 stb,
   input  logic                 cyc,
   output logic [WB_W_DATA-1:0] WBM_DAT_o,
   output logic                 ack,
   output logic [WB_WIDTH-1:0]  BASEADDR_s,
   output logic [AW-1:0]        slv_adr,
   output logic                 stb0,
   output logic                 stb1,
   input  logic [WB_W_DATA-1:0] dat0,
   input  logic                 ack0,
   input  logic [WB_W_DATA-1:0] dat1,
   input  logic                 ack1
);
   logic sel, rsp_sel;
   logic unused_adr;

   assign sel        = adr[WB_WIDTH-1];
   assign BASEADDR_s = sel ? {1'b1, {(WB_WIDTH-1){1'b0}}} : '0;
   assign stb0       = stb & cyc & ~sel;
   assign stb1       = stb & cyc & sel;
   assign slv_adr    = adr[AW-1:0];
   assign unused_adr = ^adr[WB_WIDTH-2:AW];

   // Response mux follows whichever slave was addressed on the last clocked transfer,
   // so read data stays stable while the bus idles or retargets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          rsp_sel <= 1'b0;
      else if (stb && cyc) rsp_sel <= sel;
   end

   assign WBM_DAT_o = rsp_sel ? dat1 : dat0;
   assign ack       = rsp_sel ? ack1 : ack0;
endmodule

module wishbone_slave #(
   parameter int WB_W_DATA = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AW-1:0]        adr,
   input  logic [WB_W_DATA-1:0] dat_i,
   input  logic                 we,
   input  logic                 stb,
   input  logic                 cyc,
   output logic [WB_W_DATA-1:0] dat_o,
   output logic                 ack
);
   logic [WB_W_DATA-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         dat_o <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         ack <= stb & cyc;
         if (stb && cyc) begin
            if (we) mem[adr] <= dat_i;
            else    dat_o    <= mem[adr];
         end
      end
   end
endmodule

module wishbone_system_top #(
   parameter int WB_WIDTH  = 16,
   parameter int WB_W_DATA = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic CLK_i,
   input  logic RST_i
);
   localparam int AW = $clog2(MEM_DEPTH);

   logic [WB_WIDTH-1:0]  adr, base;
   logic [WB_W_DATA-1:0] mdat, rdat, dat0, dat1;
   logic                 we, stb, cyc, ack, ack0, ack1, stb0, stb1;
   logic [AW-1:0]        slv_adr;
   logic                 unused_base;

   wishbone_master #(.WB_WIDTH(WB_WIDTH), .WB_W_DATA(WB_W_DATA)) u_wishbone_master (
      .CLK_i(CLK_i), .RST_i(RST_i),
      .WBM_ADR_o(adr), .WBM_DAT_o(mdat), .WBM_WE_o(we), .WBM_STB_o(stb), .WBM_CYC_o(cyc),
      .WBM_DAT_i(rdat), .WBM_ACK_i(ack)
   );

   wishbone_interface #(.WB_WIDTH(WB_WIDTH), .WB_W_DATA(WB_W_DATA), .AW(AW)) u_wishbone_interface (
      .clk(CLK_i), .rst_n(RST_i), .adr(adr), .stb(stb), .cyc(cyc),
      .WBM_DAT_o(rdat), .ack(ack), .BASEADDR_s(base), .slv_adr(slv_adr),
      .stb0(stb0), .stb1(stb1), .dat0(dat0), .ack0(ack0), .dat1(dat1), .ack1(ack1)
   );

   wishbone_slave #(.WB_W_DATA(WB_W_DATA), .MEM_DEPTH(MEM_DEPTH)) u_wishbone_slave0 (
      .clk(CLK_i), .rst_n(RST_i), .adr(slv_adr), .dat_i(mdat), .we(we),
      .stb(stb0), .cyc(cyc), .dat_o(dat0), .ack(ack0)
   );

   wishbone_slave #(.WB_W_DATA(WB_W_DATA), .MEM_DEPTH(MEM_DEPTH)) u_wishbone_slave1 (
      .clk(CLK_i), .rst_n(RST_i), .adr(slv_adr), .dat_i(mdat), .we(we),
      .stb(stb1), .cyc(cyc), .dat_o(dat1), .ack(ack1)
   );

   assign unused_base = ^base;
endmodule

// File: tb/tb_wishbone_system_top.sv
// Bench for wishbone_system_top: directed bring-up sequence then random traffic
// checked against an array model of the two slave memories.

module tb_wishbone_system_top;
   logic CLK_i = 1'b0;
   logic RST_i = 1'b0;

   wishbone_system_top dut (.CLK_i(CLK_i), .RST_i(RST_i));

   always #5 CLK_i = ~CLK_i;

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] model_mem [2][256];
   logic [7:0] model_dat [2];
   int         model_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) model_mem[s][i] = 8'h00;
         model_dat[s] = 8'h00;
      end
      model_sel = 0;
   endtask

   // One bus cycle: deposit request on the falling edge, clock it, sample 1ns later.
   task automatic xfer(input string tag, input logic [15:0] a, input logic [7:0] d,
                       input logic w, input logic s, input logic c);
      int sl;
      logic exp_ack;
      @(negedge CLK_i);
      dut.u_wishbone_master.address      = a;
      dut.u_wishbone_master.data         = d;
      dut.u_wishbone_master.write_enable = w;
      dut.u_wishbone_master.strobe       = s;
      dut.u_wishbone_master.cycle        = c;
      #1;
      chk({tag, ".base"}, {16'h0, dut.u_wishbone_interface.BASEADDR_s}, a[15] ? 32'h8000 : 32'h0);
      @(posedge CLK_i);
      #1;
      sl = a[15] ? 1 : 0;
      exp_ack = s & c;
      if (s && c) begin
         if (w) model_mem[sl][a[7:0]] = d;
         else   model_dat[sl] = model_mem[sl][a[7:0]];
         model_sel = sl;
      end
      chk({tag, ".ack"}, {31'h0, dut.u_wishbone_master.WBM_ACK_i}, {31'h0, exp_ack});
      chk({tag, ".dat"}, {24'h0, dut.u_wishbone_interface.WBM_DAT_o}, {24'h0, model_dat[model_sel]});
   endtask

   initial begin
      model_reset();
      // Reset pulse
      RST_i = 1'b0;
      #10;
      RST_i = 1'b1;
      #1;
      chk("rst.ack",  {31'h0, dut.u_wishbone_master.WBM_ACK_i}, 32'h0);
      chk("rst.dat",  {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h0);
      chk("rst.adr",  {16'h0, dut.u_wishbone_master.WBM_ADR_o}, 32'h0);
      chk("rst.base", {16'h0, dut.u_wishbone_interface.BASEADDR_s}, 32'h0);

      xfer("wr0000", 16'h0000, 8'hAA, 1'b1, 1'b1, 1'b1);
      chk("mem0", {24'h0, dut.u_wishbone_slave0.mem[0]}, 32'hAA);
      xfer("rd0000", 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("rd0000.v", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'hAA);
      xfer("wr8003", 16'h8003, 8'h55, 1'b1, 1'b1, 1'b1);
      xfer("rd8003", 16'h8003, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("rd8003.v", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h55);
      xfer("rd0003", 16'h0003, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("rd0003.v", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h00);
      xfer("wr0105", 16'h0105, 8'h3C, 1'b1, 1'b1, 1'b1);
      xfer("rd0005", 16'h0005, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("alias.v", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h3C);

      // Strobe without cycle must neither ack nor write
      xfer("nocyc", 16'h0005, 8'h77, 1'b1, 1'b1, 1'b0);
      xfer("rdkeep", 16'h0005, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("nocyc.v", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h3C);

      // Reset asserted while a read is being acknowledged
      #1;
      RST_i = 1'b0;
      #1;
      chk("midrst.ack", {31'h0, dut.u_wishbone_master.WBM_ACK_i}, 32'h0);
      chk("midrst.dat", {24'h0, dut.u_wishbone_master.WBM_DAT_i}, 32'h0);
      model_reset();
      #10;
      @(negedge CLK_i);
      RST_i = 1'b1;
      xfer("postrst", 16'h0005, 8'h00, 1'b0, 1'b1, 1'b1);

      // Random traffic: 16 live words per slave, aliasing through the upper address bits
      for (int n = 0; n < 300; n++) begin
         logic [15:0] a;
         a = {1'($urandom), 7'($urandom), 4'h0, 4'($urandom)};
         xfer("rand", a, 8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 7) != 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
